// File: rtl/etapa_ex_multdiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage, owning the HI/LO registers.
// One shift-add or restoring-divide iteration per stepped cycle; signs are fixed up in a final cycle.
module etapa_ex_multdiv #(
  parameter int NBITS   = 32,
  parameter int CNTBITS = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Step,
  input  logic             i_Flush,
  input  logic             i_Start,
  input  logic [1:0]       i_Op,
  input  logic [NBITS-1:0] i_Registro1,
  input  logic [NBITS-1:0] i_Registro2,
  input  logic             i_MTHI,
  input  logic             i_MTLO,
  output logic [NBITS-1:0] o_HI,
  output logic [NBITS-1:0] o_LO,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t               state;
  logic [CNTBITS-1:0]   cnt;
  logic                 is_div, div_zero, neg_lo, neg_hi, done;
  logic [NBITS-1:0]     hi, lo, opa, opb, raw_rs, quo, rem;
  logic [2*NBITS-1:0]   acc;

  logic                 is_signed;
  logic [NBITS-1:0]     mag_a, mag_b;
  logic [NBITS:0]       mul_sum, div_shift, div_diff;
  logic [2*NBITS-1:0]   prod_fix;
  logic [NBITS-1:0]     quo_fix, rem_fix;

  // Handshake: a start is accepted only on a stepped edge in IDLE with i_Flush low;
  // o_Busy is the "not ready" signal and upstream must hold off while it is high.
  assign is_signed = ~i_Op[0];

  always_comb begin
    mag_a     = (is_signed && i_Registro1[NBITS-1]) ? -i_Registro1 : i_Registro1;
    mag_b     = (is_signed && i_Registro2[NBITS-1]) ? -i_Registro2 : i_Registro2;
    // Multiply: add multiplicand into the upper half when the current multiplier bit is set.
    mul_sum   = {1'b0, acc[2*NBITS-1:NBITS]} + (acc[0] ? {1'b0, opa} : '0);
    // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
    div_shift = {rem, quo[NBITS-1]};
    div_diff  = div_shift - {1'b0, opb};
    prod_fix  = neg_lo ? -acc : acc;
    quo_fix   = neg_lo ? -quo : quo;
    rem_fix   = neg_hi ? -rem : rem;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opa      <= '0;
      opb      <= '0;
      raw_rs   <= '0;
      quo      <= '0;
      rem      <= '0;
      acc      <= '0;
    end else if (i_Step) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start && !i_Flush) begin
            state    <= RUN;
            cnt      <= '0;
            is_div   <= i_Op[1];
            div_zero <= (i_Registro2 == '0);
            neg_lo   <= is_signed & (i_Registro1[NBITS-1] ^ i_Registro2[NBITS-1]);
            neg_hi   <= is_signed & i_Op[1] & i_Registro1[NBITS-1];
            raw_rs   <= i_Registro1;
            opa      <= mag_a;
            opb      <= mag_b;
            acc      <= {{NBITS{1'b0}}, mag_b};
            quo      <= mag_a;
            rem      <= '0;
          end else if (!i_Flush) begin
            if (i_MTHI) hi <= i_Registro1;
            if (i_MTLO) lo <= i_Registro1;
          end
        end
        RUN: begin
          if (is_div) begin
            if (div_diff[NBITS]) begin
              rem <= div_shift[NBITS-1:0];
              quo <= {quo[NBITS-2:0], 1'b0};
            end else begin
              rem <= div_diff[NBITS-1:0];
              quo <= {quo[NBITS-2:0], 1'b1};
            end
          end else begin
            acc <= {mul_sum, acc[NBITS-1:1]};
          end
          if (cnt == CNTBITS'(NBITS-1)) state <= FIX;
          else                          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*NBITS-1:NBITS];
            lo <= prod_fix[NBITS-1:0];
          end else if (div_zero) begin
            hi <= raw_rs;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_HI    = hi;
  assign o_LO    = lo;
  assign o_Busy  = (state != IDLE);
  assign o_Done  = done;
  assign o_state = state;

endmodule

// File: tb/tb_etapa_ex_multdiv.sv
// Self-checking bench for etapa_ex_multdiv: directed spec cases plus randomized ops
// checked against a plain-arithmetic HI/LO model.
module tb_etapa_ex_multdiv;
  localparam int NBITS = 32;

  logic             clk = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_Step = 1'b0, i_Flush = 1'b0, i_Start = 1'b0;
  logic [1:0]       i_Op = 2'b00;
  logic [NBITS-1:0] i_Registro1 = '0, i_Registro2 = '0;
  logic             i_MTHI = 1'b0, i_MTLO = 1'b0;
  logic [NBITS-1:0] o_HI, o_LO;
  logic             o_Busy, o_Done;
  logic [1:0]       o_state;

  int checks = 0;
  int errors = 0;
  logic [NBITS-1:0] exp_q[$];

  etapa_ex_multdiv #(.NBITS(NBITS), .CNTBITS(6)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_Step(i_Step), .i_Flush(i_Flush),
    .i_Start(i_Start), .i_Op(i_Op), .i_Registro1(i_Registro1), .i_Registro2(i_Registro2),
    .i_MTHI(i_MTHI), .i_MTLO(i_MTLO), .o_HI(o_HI), .o_LO(o_LO),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Reference: full-width integer arithmetic, SV division truncates toward zero.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] up;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
      2'b10: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin hi = a % b; lo = a / b; end
      end
    endcase
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit toggle, input bit noise, input bit mt_with_start, input string name);
    logic [31:0] eh, el;
    int stepped, cyc;
    model(op, a, b, eh, el);
    exp_q.push_back(eh);
    exp_q.push_back(el);
    @(negedge clk);
    i_Step = 1'b1; i_Flush = 1'b0; i_Start = 1'b1; i_Op = op;
    i_Registro1 = a; i_Registro2 = b; i_MTHI = mt_with_start; i_MTLO = 1'b0;
    @(negedge clk);
    i_Start = 1'b0; i_MTHI = 1'b0;
    checks++;
    if (o_Busy !== 1'b1) begin errors++; $display("FAIL %s accept: busy=%b expected 1", name, o_Busy); end
    stepped = 0; cyc = 0;
    while (o_Busy === 1'b1 && cyc < 200) begin
      i_Step = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (noise) begin
        i_MTHI = 1'b1; i_Registro1 = 32'h1234;
        i_MTLO = 1'($urandom_range(0, 1)); i_Flush = 1'($urandom_range(0, 1));
        i_Start = 1'($urandom_range(0, 1)); i_Op = 2'($urandom_range(0, 3));
        i_Registro2 = $urandom;
      end
      if (i_Step) stepped++;
      @(negedge clk);
      cyc++;
    end
    i_Start = 1'b0; i_MTHI = 1'b0; i_MTLO = 1'b0; i_Flush = 1'b0;
    checks++;
    if (stepped != NBITS + 1) begin errors++; $display("FAIL %s latency: stepped edges=%0d expected %0d", name, stepped, NBITS + 1); end
    checks++;
    if (o_Done !== 1'b1) begin errors++; $display("FAIL %s done: got %b expected 1", name, o_Done); end
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    checks++;
    if (o_HI !== eh) begin errors++; $display("FAIL %s hi: got %h expected %h", name, o_HI, eh); end
    checks++;
    if (o_LO !== el) begin errors++; $display("FAIL %s lo: got %h expected %h", name, o_LO, el); end
    i_Step = 1'b0;
    @(negedge clk);
    checks++;
    if (o_Done !== 1'b1) begin errors++; $display("FAIL %s done_hold_unstepped: got %b expected 1", name, o_Done); end
    i_Step = 1'b1;
    @(negedge clk);
    checks++;
    if (o_Done !== 1'b0) begin errors++; $display("FAIL %s done_clear: got %b expected 0", name, o_Done); end
    checks++;
    if (o_HI !== eh || o_LO !== el) begin errors++; $display("FAIL %s hold: got %h/%h expected %h/%h", name, o_HI, o_LO, eh, el); end
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_HI !== '0 || o_LO !== '0) begin errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", o_HI, o_LO); end
    checks++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b expected 0/0", o_Busy, o_Done); end
    checks++;
    if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
  endtask

  task automatic test_mt();
    @(negedge clk);
    i_Step = 1'b1; i_MTHI = 1'b1; i_Registro1 = 32'hA5A5_0001;
    @(negedge clk);
    i_MTHI = 1'b0; i_MTLO = 1'b1; i_Registro1 = 32'h0BAD_F00D;
    @(negedge clk);
    i_MTLO = 1'b0;
    checks++;
    if (o_HI !== 32'hA5A5_0001 || o_LO !== 32'h0BAD_F00D) begin errors++; $display("FAIL mt_write: got %h/%h expected a5a50001/0badf00d", o_HI, o_LO); end
    i_MTHI = 1'b1; i_MTLO = 1'b1; i_Flush = 1'b1; i_Registro1 = 32'h1111_2222;
    @(negedge clk);
    i_Flush = 1'b0; i_Step = 1'b0;
    @(negedge clk);
    i_MTHI = 1'b0; i_MTLO = 1'b0; i_Step = 1'b1;
    checks++;
    if (o_HI !== 32'hA5A5_0001 || o_LO !== 32'h0BAD_F00D) begin errors++; $display("FAIL mt_blocked: got %h/%h expected a5a50001/0badf00d", o_HI, o_LO); end
  endtask

  task automatic test_start_blocked();
    @(negedge clk);
    i_Step = 1'b1; i_Flush = 1'b1; i_Start = 1'b1; i_Op = 2'b01;
    i_Registro1 = 32'd5; i_Registro2 = 32'd6;
    @(negedge clk);
    checks++;
    if (o_Busy !== 1'b0) begin errors++; $display("FAIL flush_start: busy=%b expected 0", o_Busy); end
    i_Flush = 1'b0; i_Step = 1'b0;
    @(negedge clk);
    i_Start = 1'b0; i_Step = 1'b1;
    checks++;
    if (o_Busy !== 1'b0) begin errors++; $display("FAIL unstepped_start: busy=%b expected 0", o_Busy); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    i_Step = 1'b1; i_MTHI = 1'b1; i_MTLO = 1'b1; i_Registro1 = 32'hDEAD_BEEF;
    @(negedge clk);
    i_MTHI = 1'b0; i_MTLO = 1'b0;
    i_Start = 1'b1; i_Op = 2'b00; i_Registro1 = 32'h0001_2345; i_Registro2 = 32'hFFFF_0003;
    @(negedge clk);
    i_Start = 1'b0;
    repeat (10) @(negedge clk);
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0 || o_state !== 2'd0) begin errors++; $display("FAIL reset_mid: busy=%b done=%b state=%0d expected 0/0/0", o_Busy, o_Done, o_state); end
    checks++;
    if (o_HI !== '0 || o_LO !== '0) begin errors++; $display("FAIL reset_mid_hilo: got %h/%h expected 0/0", o_HI, o_LO); end
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0, 1'b0, "mult_neg");
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "multu_max");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, "div_neg7_2");
    do_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0, "divu_zero");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 1'b0, "div_zero");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "div_minint");
    do_op(2'b11, 32'd7, 32'd2, 1'b1, 1'b0, 1'b0, "divu_stepped");
    do_op(2'b10, 32'd1000, 32'hFFFF_FFF9, 1'b0, 1'b1, 1'b0, "busy_ignore");
    do_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1, "start_over_mt");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0] op;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      do_op(op, a, b, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, "b2b_mult");
    do_op(2'b11, 32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0, 1'b0, "b2b_divu");
  endtask

  initial begin
    test_reset();
    test_mt();
    test_start_blocked();
    test_directed();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
